// File: rtl/ship_game_ctrl.sv
// Battleship game sequencer: ship placement for both boards, alternating turns with a
// player turn timer, hit counting and winner detection. Owns no board storage.
module ship_game_ctrl #(
  parameter int unsigned CYC_PER_SEC = 50_000_000,
  parameter int unsigned TURN_SECS   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] ship_count,
  input  logic       player_placed,
  input  logic       eplace_done,
  input  logic       player_shot,
  input  logic       player_hit,
  input  logic       enemy_shot,
  input  logic       enemy_hit,
  output logic [2:0] state,
  output logic [2:0] cur_size,
  output logic       player_place_req,
  output logic       eplace_en,
  output logic [2:0] eplace_size,
  output logic       enemy_fire_req,
  output logic [3:0] secs_left,
  output logic       timeout,
  output logic [3:0] p_hits,
  output logic [3:0] e_hits,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned SubW = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPPlace = 3'd1,
    StEPlace = 3'd2,
    StPTurn  = 3'd3,
    StETurn  = 3'd4,
    StOver   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      n_q, n_d, n_new;
  logic [3:0]      total_q, total_d;
  logic [5:0]      prod;
  logic [2:0]      cur_size_q, cur_size_d;
  logic [SubW-1:0] sub_q, sub_d;
  logic [3:0]      secs_q, secs_d;
  logic            timeout_q, timeout_d;
  logic [3:0]      p_hits_q, p_hits_d;
  logic [3:0]      e_hits_q, e_hits_d;
  logic            winner_q, winner_d;
  logic            wrap;
  logic            place_req_q, eplace_en_q, fire_req_q, game_over_q;
  logic [2:0]      eplace_size_q;

  always_comb begin
    n_new = (ship_count == 3'd0) ? 3'd1 : (ship_count > 3'd5) ? 3'd5 : ship_count;
    prod  = {3'b000, n_new} * ({3'b000, n_new} + 6'd1);
    wrap  = (sub_q == SubW'(CYC_PER_SEC - 1));

    state_d    = state_q;
    n_d        = n_q;
    total_d    = total_q;
    cur_size_d = cur_size_q;
    sub_d      = sub_q;
    secs_d     = secs_q;
    timeout_d  = 1'b0;
    p_hits_d   = p_hits_q;
    e_hits_d   = e_hits_q;
    winner_d   = winner_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          n_d        = n_new;
          total_d    = prod[4:1];
          p_hits_d   = 4'd0;
          e_hits_d   = 4'd0;
          cur_size_d = 3'd1;
          state_d    = StPPlace;
        end
      end
      StPPlace: if (player_placed) state_d = StEPlace;
      StEPlace: begin
        if (eplace_done) begin
          if (cur_size_q == n_q) begin
            cur_size_d = 3'd0;
            state_d    = StPTurn;
          end else begin
            cur_size_d = cur_size_q + 3'd1;
            state_d    = StPPlace;
          end
        end
      end
      StPTurn: begin
        // A shot on the expiry cycle takes priority over the timeout.
        if (player_shot) begin
          p_hits_d = p_hits_q + {3'b000, player_hit};
          if (p_hits_d == total_q) begin
            winner_d = 1'b0;
            state_d  = StOver;
          end else begin
            state_d = StETurn;
          end
        end else if (wrap && secs_q == 4'd1) begin
          timeout_d = 1'b1;
          state_d   = StETurn;
        end else if (wrap) begin
          sub_d  = '0;
          secs_d = secs_q - 4'd1;
        end else begin
          sub_d = sub_q + SubW'(1);
        end
      end
      StETurn: begin
        if (enemy_shot) begin
          e_hits_d = e_hits_q + {3'b000, enemy_hit};
          if (e_hits_d == total_q) begin
            winner_d = 1'b1;
            state_d  = StOver;
          end else begin
            state_d = StPTurn;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Timer reloads on every entry into the player turn and reads 0 elsewhere.
    if (state_d != StPTurn) begin
      secs_d = 4'd0;
      sub_d  = '0;
    end else if (state_q != StPTurn) begin
      secs_d = 4'(TURN_SECS);
      sub_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      n_q           <= 3'd0;
      total_q       <= 4'd0;
      cur_size_q    <= 3'd0;
      sub_q         <= '0;
      secs_q        <= 4'd0;
      timeout_q     <= 1'b0;
      p_hits_q      <= 4'd0;
      e_hits_q      <= 4'd0;
      winner_q      <= 1'b0;
      place_req_q   <= 1'b0;
      eplace_en_q   <= 1'b0;
      eplace_size_q <= 3'd0;
      fire_req_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      total_q       <= total_d;
      cur_size_q    <= cur_size_d;
      sub_q         <= sub_d;
      secs_q        <= secs_d;
      timeout_q     <= timeout_d;
      p_hits_q      <= p_hits_d;
      e_hits_q      <= e_hits_d;
      winner_q      <= winner_d;
      place_req_q   <= (state_d == StPPlace);
      eplace_en_q   <= (state_d == StEPlace);
      eplace_size_q <= (state_d == StEPlace) ? cur_size_d : 3'd0;
      fire_req_q    <= (state_d == StETurn);
      game_over_q   <= (state_d == StOver);
    end
  end

  assign state            = state_q;
  assign cur_size         = cur_size_q;
  assign player_place_req = place_req_q;
  assign eplace_en        = eplace_en_q;
  assign eplace_size      = eplace_size_q;
  assign enemy_fire_req   = fire_req_q;
  assign secs_left        = secs_q;
  assign timeout          = timeout_q;
  assign p_hits           = p_hits_q;
  assign e_hits           = e_hits_q;
  assign game_over        = game_over_q;
  assign winner           = winner_q;

endmodule

// File: tb/tb_ship_game_ctrl.sv
// Bench for ship_game_ctrl: directed scenarios plus random play, all outputs compared every
// cycle against a turn/phase-level game model.
module tb_ship_game_ctrl;

  localparam int unsigned CYC  = 4;
  localparam int unsigned SECS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] ship_count = 3'd0;
  logic       player_placed = 1'b0, eplace_done = 1'b0;
  logic       player_shot = 1'b0, player_hit = 1'b0;
  logic       enemy_shot = 1'b0, enemy_hit = 1'b0;
  logic [2:0] state, cur_size, eplace_size;
  logic       player_place_req, eplace_en, enemy_fire_req, timeout, game_over, winner;
  logic [3:0] secs_left, p_hits, e_hits;

  always #5 clk = ~clk;

  ship_game_ctrl #(.CYC_PER_SEC(CYC), .TURN_SECS(SECS)) dut (
    .clk(clk), .rst(rst), .start(start), .ship_count(ship_count),
    .player_placed(player_placed), .eplace_done(eplace_done),
    .player_shot(player_shot), .player_hit(player_hit),
    .enemy_shot(enemy_shot), .enemy_hit(enemy_hit),
    .state(state), .cur_size(cur_size), .player_place_req(player_place_req),
    .eplace_en(eplace_en), .eplace_size(eplace_size), .enemy_fire_req(enemy_fire_req),
    .secs_left(secs_left), .timeout(timeout), .p_hits(p_hits), .e_hits(e_hits),
    .game_over(game_over), .winner(winner)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Game model: phase code, ships, hit tallies, and cycles remaining in the player turn.
  int m_state = 0, m_cur = 0, m_n = 0, m_total = 0, m_p = 0, m_e = 0, m_win = 0;
  int m_left = 0, m_to = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int sc;
    m_to = 0;
    if (!rst) begin
      m_state = 0; m_cur = 0; m_n = 0; m_total = 0; m_p = 0; m_e = 0; m_win = 0; m_left = 0;
    end else begin
      case (m_state)
        0, 5: if (start) begin
          sc = int'(ship_count);
          m_n = (sc < 1) ? 1 : (sc > 5) ? 5 : sc;
          m_total = m_n * (m_n + 1) / 2;
          m_p = 0; m_e = 0; m_cur = 1; m_state = 1;
        end
        1: if (player_placed) m_state = 2;
        2: if (eplace_done) begin
          if (m_cur == m_n) begin
            m_cur = 0; m_state = 3; m_left = SECS * CYC;
          end else begin
            m_cur++; m_state = 1;
          end
        end
        3: begin
          if (player_shot) begin
            m_p += int'(player_hit);
            if (m_p == m_total) begin m_win = 0; m_state = 5; end
            else m_state = 4;
          end else if (m_left == 1) begin
            m_to = 1; m_state = 4;
          end else begin
            m_left--;
          end
        end
        4: if (enemy_shot) begin
          m_e += int'(enemy_hit);
          if (m_e == m_total) begin m_win = 1; m_state = 5; end
          else begin m_state = 3; m_left = SECS * CYC; end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("state", int'(state), m_state);
    check_eq("cur_size", int'(cur_size), m_cur);
    check_eq("player_place_req", int'(player_place_req), int'(m_state == 1));
    check_eq("eplace_en", int'(eplace_en), int'(m_state == 2));
    check_eq("eplace_size", int'(eplace_size), (m_state == 2) ? m_cur : 0);
    check_eq("enemy_fire_req", int'(enemy_fire_req), int'(m_state == 4));
    check_eq("secs_left", int'(secs_left), (m_state == 3) ? (m_left + CYC - 1) / CYC : 0);
    check_eq("timeout", int'(timeout), m_to);
    check_eq("p_hits", int'(p_hits), m_p);
    check_eq("e_hits", int'(e_hits), m_e);
    check_eq("game_over", int'(game_over), int'(m_state == 5));
    if (m_state == 5) check_eq("winner", int'(winner), m_win);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Starts a game and runs placement; returns ships placed and the DUT eplace_size seen per ship.
  task automatic place_all(input logic [2:0] sc, output int ships, output int sizes[5]);
    ships = 0;
    for (int i = 0; i < 5; i++) sizes[i] = -1;
    start = 1'b1; ship_count = sc;
    step();
    start = 1'b0;
    for (int k = 0; k < 300 && m_state != 3; k++) begin
      if (m_state == 1) begin
        step(); step();
        player_placed = 1'b1; step(); player_placed = 1'b0;
      end else if (m_state == 2) begin
        if (ships < 5) sizes[ships] = int'(eplace_size);
        ships++;
        step(); step(); step();
        eplace_done = 1'b1; step(); eplace_done = 1'b0;
      end else begin
        step();
      end
    end
    check_eq("placement_done", m_state, 3);
  endtask

  initial begin
    int ships;
    int sizes[5];
    int to_cnt;

    rst = 1'b0;
    step(); step();
    rst = 1'b1;

    // Three ships, then an unanswered player turn.
    place_all(3'd3, ships, sizes);
    check_eq("ships_n3", ships, 3);
    for (int i = 0; i < 3; i++) check_eq("eplace_size_seq", sizes[i], i + 1);
    check_eq("cur_size_after_place", int'(cur_size), 0);
    to_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      to_cnt += int'(timeout);
    end
    check_eq("timeout_count", to_cnt, 1);
    check_eq("state_after_timeout", int'(state), 4);
    check_eq("p_hits_after_timeout", int'(p_hits), 0);

    // Single ship, player hits immediately.
    do_reset();
    place_all(3'd1, ships, sizes);
    player_shot = 1'b1; player_hit = 1'b1; step(); player_shot = 1'b0; player_hit = 1'b0;
    check_eq("p_win_state", int'(state), 5);
    check_eq("p_win_over", int'(game_over), 1);
    check_eq("p_win_winner", int'(winner), 0);
    check_eq("p_win_hits", int'(p_hits), 1);

    // Two ships, enemy hits every shot, player always misses.
    do_reset();
    place_all(3'd2, ships, sizes);
    for (int k = 0; k < 200 && m_state != 5; k++) begin
      if (m_state == 3) begin
        player_shot = 1'b1; player_hit = 1'b0; step(); player_shot = 1'b0;
      end else if (m_state == 4) begin
        enemy_shot = 1'b1; enemy_hit = 1'b1; step(); enemy_shot = 1'b0; enemy_hit = 1'b0;
      end else begin
        step();
      end
    end
    check_eq("e_win_winner", int'(winner), 1);
    check_eq("e_win_e_hits", int'(e_hits), 3);
    check_eq("e_win_p_hits", int'(p_hits), 0);

    // Shot on the exact expiry cycle of the turn (started from OVER).
    place_all(3'd2, ships, sizes);
    for (int i = 0; i < SECS * CYC - 1; i++) step();
    player_shot = 1'b1; player_hit = 1'b1; step(); player_shot = 1'b0; player_hit = 1'b0;
    check_eq("expiry_shot_timeout", int'(timeout), 0);
    check_eq("expiry_shot_hits", int'(p_hits), 1);
    check_eq("expiry_shot_state", int'(state), 4);

    // Reset in the middle of enemy placement.
    do_reset();
    start = 1'b1; ship_count = 3'd3; step(); start = 1'b0;
    player_placed = 1'b1; step(); player_placed = 1'b0;
    step();
    check_eq("mid_eplace_en", int'(eplace_en), 1);
    rst = 1'b0; step(); rst = 1'b1;
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_eplace_en", int'(eplace_en), 0);

    // Clamping of ship_count.
    place_all(3'd0, ships, sizes);
    check_eq("ships_n0", ships, 1);
    do_reset();
    place_all(3'd7, ships, sizes);
    check_eq("ships_n7", ships, 5);
    for (int i = 0; i < 5; i++) check_eq("eplace_size_n7", sizes[i], i + 1);

    // Random play.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 499) != 0);
      start         = ($urandom_range(0, 3) == 0);
      ship_count    = 3'($urandom_range(0, 7));
      player_placed = ($urandom_range(0, 2) == 0);
      eplace_done   = ($urandom_range(0, 2) == 0);
      player_shot   = ($urandom_range(0, 15) == 0);
      player_hit    = ($urandom_range(0, 1) == 0);
      enemy_shot    = ($urandom_range(0, 2) == 0);
      enemy_hit     = ($urandom_range(0, 1) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
